// File: rtl/debounce_pkg.sv
// Shared types and limits for the input debouncer and related
// raw-input conditioning blocks.
package debounce_pkg;

  // Bit 1 is the accepted level; bit 0 xor bit 1 marks a pending candidate.
  typedef enum logic [1:0] {
    ST_LOW    = 2'b00,
    PEND_HIGH = 2'b01,
    ST_HIGH   = 2'b11,
    PEND_LOW  = 2'b10
  } db_state_t;

  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int DB_MIN   = 2;
  localparam int DB_MAX   = 65535;

  function automatic logic is_pend(db_state_t st);
    return st[1] ^ st[0];
  endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop single-bit synchronizer for asynchronous inputs.
// Output is the last stage only.
module sync_chain #(
  parameter int N = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stages <= '0;
    else          stages <= {stages[N-2:0], d};
  end

  assign q = stages[N-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces an asynchronous raw input into a clean registered level and
// counts rejected candidate transitions (saturating).
module input_debouncer
  import debounce_pkg::*;
#(
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                raw_in,
  input  logic                glitch_clear,
  output logic                data,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_count
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("input_debouncer: SYNC_STAGES out of range");
  end
  if (DEBOUNCE_CYCLES < DB_MIN || DEBOUNCE_CYCLES > DB_MAX) begin : g_bad_db
    $error("input_debouncer: DEBOUNCE_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             glitch;

  sync_chain #(.N(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (raw_in),
    .q       (s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A sample back at the accepted level aborts the candidate; the next
  // differing sample restarts qualification from scratch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    glitch    = 1'b0;
    case (state)
      ST_LOW: begin
        if (s) begin
          state_nxt = PEND_HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      PEND_HIGH: begin
        if (!s) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
          glitch    = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_nxt = PEND_LOW;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      PEND_LOW: begin
        if (s) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
          glitch    = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Clear wins over a same-cycle glitch event.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                             glitch_count <= '0;
    else if (glitch_clear)                    glitch_count <= '0;
    else if (glitch && glitch_count != GLITCH_MAX) glitch_count <= glitch_count + 1'b1;
  end

  assign data = state[1];
  assign busy = is_pend(state);

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboarded bench for input_debouncer: stimulus queues expected output
// changes (edge number and values); a monitor pops one per observed change.
module tb_input_debouncer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       raw_in = 1'b0;
  logic       glitch_clear = 1'b0;
  logic       data;
  logic       busy;
  logic [7:0] glitch_count;

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .glitch_clear (glitch_clear),
    .data         (data),
    .busy         (busy),
    .glitch_count (glitch_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string nm;
    int    cyc;
    logic  d;
    logic  b;
    int    g;
  } ev_t;

  ev_t  q[$];
  int   checks = 0;
  int   errors = 0;
  int   rises  = 0;
  int   falls  = 0;
  int   gexp   = 0;
  logic pd = 1'b0;
  logic pb = 1'b0;
  logic [7:0] pg = 8'd0;

  // Monitor: every output change must match the head of the queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      if (data === 1'b1 && pd === 1'b0) rises++;
      if (data === 1'b0 && pd === 1'b1) falls++;
      if (data !== pd || busy !== pb || glitch_count !== pg) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d data=%0b busy=%0b glitch=%0d",
                   cyc, data, busy, glitch_count);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || data !== e.d || busy !== e.b || int'(glitch_count) != e.g) begin
            errors++;
            $display("FAIL %s got cyc=%0d data=%0b busy=%0b glitch=%0d expected cyc=%0d data=%0b busy=%0b glitch=%0d",
                     e.nm, cyc, data, busy, glitch_count, e.cyc, e.d, e.b, e.g);
          end
        end
      end
      pd = data;
      pb = busy;
      pg = glitch_count;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic expect_ev(string nm, int c, logic d, logic b, int g);
    ev_t e;
    e.nm = nm; e.cyc = c; e.d = d; e.b = b; e.g = g;
    q.push_back(e);
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Clean step: busy at E3, data at E18 (E1 = first edge after drive).
  task automatic step(logic v);
    int k;
    k = cyc;
    raw_in = v;
    expect_ev("step_busy_rise", k + 3, !v, 1'b1, gexp);
    expect_ev("step_accept", k + 18, v, 1'b0, gexp);
  endtask

  // Short excursion away from the accepted level; aborts at edge k+len+3.
  task automatic pulse(logic lvl, int len);
    int k, g2;
    k  = cyc;
    g2 = (gexp < 255) ? gexp + 1 : 255;
    raw_in = !lvl;
    expect_ev("pulse_busy_rise", k + 3, lvl, 1'b1, gexp);
    expect_ev("pulse_abort", k + len + 3, lvl, 1'b0, g2);
    tick(len);
    raw_in = lvl;
    gexp = g2;
  endtask

  initial begin
    int k, j;
    #2;
    chk("reset_data", int'(data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_glitch", int'(glitch_count), 0);
    tick(3);
    reset_n = 1'b1;
    tick(5);

    // clean rise and fall
    step(1'b1); tick(40);
    step(1'b0); tick(40);

    // bounce 1,0,1,0 in 3-cycle phases, then hold high
    pulse(1'b0, 3); tick(3);
    pulse(1'b0, 3); tick(3);
    step(1'b1); tick(40);
    chk("bounce_glitch_count", int'(glitch_count), 2);

    // low-going glitch while high, then return low
    pulse(1'b1, 5); tick(30);
    step(1'b0); tick(40);

    // clear on the same edge a PEND_HIGH aborts
    k = cyc;
    raw_in = 1'b1;
    expect_ev("clear_vs_glitch_busy", k + 3, 1'b0, 1'b1, gexp);
    expect_ev("clear_vs_glitch", k + 8, 1'b0, 1'b0, 0);
    tick(5); raw_in = 1'b0;
    tick(2); glitch_clear = 1'b1;
    tick(1); glitch_clear = 1'b0;
    gexp = 0;
    tick(30);

    // saturation
    for (int i = 0; i < 300; i++) begin
      pulse(1'b0, 5);
      tick(30);
    end
    chk("saturated_glitch", int'(glitch_count), 255);
    chk("saturated_data", int'(data), 0);
    k = cyc;
    glitch_clear = 1'b1;
    expect_ev("clear_from_sat", k + 1, 1'b0, 1'b0, 0);
    tick(1);
    glitch_clear = 1'b0;
    gexp = 0;
    chk("cleared_glitch", int'(glitch_count), 0);
    tick(5);

    // reset mid PEND_HIGH at cnt=10, raw held high through release
    pulse(1'b0, 5); tick(30);
    k = cyc;
    raw_in = 1'b1;
    expect_ev("rst_busy_rise", k + 3, 1'b0, 1'b1, gexp);
    tick(12);
    reset_n = 1'b0;
    expect_ev("rst_async_clear", k + 13, 1'b0, 1'b0, 0);
    gexp = 0;
    #1;
    chk("rst_mid_data", int'(data), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_glitch", int'(glitch_count), 0);
    tick(3);
    j = cyc;
    reset_n = 1'b1;
    expect_ev("post_rst_busy", j + 3, 1'b0, 1'b1, 0);
    expect_ev("post_rst_accept", j + 18, 1'b1, 1'b0, 0);
    tick(40);

    // final fall, then downstream edge tally
    step(1'b0); tick(40);
    tick(5);
    chk("events_pending", q.size(), 0);
    chk("rise_edges", rises, 3);
    chk("fall_edges", falls, 3);
    chk("final_data", int'(data), 0);
    chk("final_glitch", int'(glitch_count), gexp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
